// File: rtl/event_logger.sv
// Violation event logger: captures rising-edge batches with a bus snapshot and
// drains them one record per cycle into a circular (or stop-when-full) log.
module event_logger #(
    parameter int N_SRC     = 6,
    parameter int N_CPU_SRC = 3,
    parameter int CODE_W    = 3,
    parameter int TS_W      = 16,
    parameter int ADDR_W    = 16,
    parameter int MODE_WRAP = 1,
    localparam int REC_W    = TS_W + CODE_W + 34
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_SRC-1:0]  src_evt,
    input  logic [15:0]       pc,
    input  logic [15:0]       data_addr,
    input  logic              data_en,
    input  logic              data_wr,
    input  logic [15:0]       dma_addr,
    input  logic              dma_en,
    input  logic              clr_ram,
    input  logic              freeze,
    output logic [REC_W-1:0]  wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              we,
    output logic [ADDR_W:0]   log_count,
    output logic              full,
    output logic              wrapped,
    output logic [15:0]       drop_cnt,
    output logic              busy
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [N_SRC-1:0]  src_q;
    logic [N_SRC-1:0]  pend_q, pend_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              wrapped_q, wrapped_d;
    logic [15:0]       drop_q, drop_d;

    logic [TS_W-1:0]   snapTs_q;
    logic [15:0]       snapPc_q, snapDataAddr_q, snapDmaAddr_q;
    logic              snapDataEn_q, snapDataWr_q, snapDmaEn_q;

    logic [N_SRC-1:0]  edges;
    logic [N_SRC-1:0]  selOneHot;
    logic [CODE_W-1:0] selIdx;
    logic              selIsCpu;
    logic              capture;
    logic              stall;
    logic [15:0]       recAddr;
    logic              recEn, recWr;
    logic [31:0]       dropInc, dropSum;

    assign edges   = src_evt & ~src_q;
    assign busy    = |pend_q;
    assign full    = (count_q == DEPTH);
    assign stall   = (MODE_WRAP == 0) && full;
    assign capture = (|edges) && !busy && !freeze && !clr_ram;

    // Lowest pending source wins; descending scan so the last hit is the lowest index.
    always_comb begin
        selIdx    = '0;
        selOneHot = '0;
        selIsCpu  = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                selIdx    = CODE_W'(i);
                selOneHot = N_SRC'(1) << i;
                selIsCpu  = (i < N_CPU_SRC);
            end
        end
    end

    assign recAddr = selIsCpu ? snapDataAddr_q : snapDmaAddr_q;
    assign recEn   = selIsCpu ? snapDataEn_q   : snapDmaEn_q;
    assign recWr   = selIsCpu ? snapDataWr_q   : 1'b0;

    assign we        = busy && !stall;
    assign wr_data   = we ? {snapTs_q, selIdx, snapPc_q, recAddr, recEn, recWr} : '0;
    assign wr_addr   = wrAddr_q;
    assign log_count = count_q;
    assign wrapped   = wrapped_q;
    assign drop_cnt  = drop_q;

    // Lost edges plus records suppressed by a full log in stop mode, saturating.
    always_comb begin
        dropInc = 32'd0;
        if (busy || freeze) begin
            dropInc = $countones(edges);
        end
        if (busy && stall) begin
            dropInc = dropInc + 32'd1;
        end
        dropSum = {16'd0, drop_q} + dropInc;
        drop_d  = (dropSum > 32'h0000_FFFF) ? 16'hFFFF : dropSum[15:0];
    end

    always_comb begin
        ts_d      = ts_q + TS_W'(1);
        pend_d    = capture ? edges : (pend_q & ~selOneHot);
        wrAddr_d  = wrAddr_q;
        count_d   = count_q;
        wrapped_d = wrapped_q;
        if (we) begin
            wrAddr_d = wrAddr_q + ADDR_W'(1);
            if (full) begin
                wrapped_d = 1'b1;
            end else begin
                count_d = count_q + (ADDR_W + 1)'(1);
            end
        end
    end

    // Edge history keeps tracking through clear so a held level never re-logs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q          <= '0;
            pend_q         <= '0;
            ts_q           <= '0;
            wrAddr_q       <= '0;
            count_q        <= '0;
            wrapped_q      <= 1'b0;
            drop_q         <= '0;
            snapTs_q       <= '0;
            snapPc_q       <= '0;
            snapDataAddr_q <= '0;
            snapDataEn_q   <= 1'b0;
            snapDataWr_q   <= 1'b0;
            snapDmaAddr_q  <= '0;
            snapDmaEn_q    <= 1'b0;
        end else begin
            src_q <= src_evt;
            if (clr_ram) begin
                pend_q    <= '0;
                ts_q      <= '0;
                wrAddr_q  <= '0;
                count_q   <= '0;
                wrapped_q <= 1'b0;
                drop_q    <= '0;
            end else begin
                pend_q    <= pend_d;
                ts_q      <= ts_d;
                wrAddr_q  <= wrAddr_d;
                count_q   <= count_d;
                wrapped_q <= wrapped_d;
                drop_q    <= drop_d;
                if (capture) begin
                    snapTs_q       <= ts_q;
                    snapPc_q       <= pc;
                    snapDataAddr_q <= data_addr;
                    snapDataEn_q   <= data_en;
                    snapDataWr_q   <= data_wr;
                    snapDmaAddr_q  <= dma_addr;
                    snapDmaEn_q    <= dma_en;
                end
            end
        end
    end

endmodule

// File: tb/tb_event_logger.sv
// Directed bench for event_logger: default instance plus two 4-entry logs
// (stop and wrap mode) sharing the same stimulus.
module tb_event_logger;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  src_evt;
    logic [15:0] pc, data_addr, dma_addr;
    logic        data_en, data_wr, dma_en, clr_ram, freeze;

    logic [52:0] mainWrData, stopWrData, wrapWrData;
    logic [15:0] mainWrAddr;
    logic [1:0]  stopWrAddr, wrapWrAddr;
    logic [16:0] mainCount;
    logic [2:0]  stopCount, wrapCount;
    logic        mainWe, stopWe, wrapWe;
    logic        mainFull, stopFull, wrapFull;
    logic        mainWrapped, stopWrapped, wrapWrapped;
    logic [15:0] mainDrop, stopDrop, wrapDrop;
    logic        mainBusy, stopBusy, wrapBusy;

    int totalChecks = 0;
    int badChecks   = 0;

    always #5 clk = ~clk;

    event_logger dutMain (
        .clk(clk), .reset(reset), .src_evt(src_evt), .pc(pc),
        .data_addr(data_addr), .data_en(data_en), .data_wr(data_wr),
        .dma_addr(dma_addr), .dma_en(dma_en), .clr_ram(clr_ram), .freeze(freeze),
        .wr_data(mainWrData), .wr_addr(mainWrAddr), .we(mainWe),
        .log_count(mainCount), .full(mainFull), .wrapped(mainWrapped),
        .drop_cnt(mainDrop), .busy(mainBusy)
    );

    event_logger #(.ADDR_W(2), .MODE_WRAP(0)) dutStop (
        .clk(clk), .reset(reset), .src_evt(src_evt), .pc(pc),
        .data_addr(data_addr), .data_en(data_en), .data_wr(data_wr),
        .dma_addr(dma_addr), .dma_en(dma_en), .clr_ram(clr_ram), .freeze(freeze),
        .wr_data(stopWrData), .wr_addr(stopWrAddr), .we(stopWe),
        .log_count(stopCount), .full(stopFull), .wrapped(stopWrapped),
        .drop_cnt(stopDrop), .busy(stopBusy)
    );

    event_logger #(.ADDR_W(2), .MODE_WRAP(1)) dutWrap (
        .clk(clk), .reset(reset), .src_evt(src_evt), .pc(pc),
        .data_addr(data_addr), .data_en(data_en), .data_wr(data_wr),
        .dma_addr(dma_addr), .dma_en(dma_en), .clr_ram(clr_ram), .freeze(freeze),
        .wr_data(wrapWrData), .wr_addr(wrapWrAddr), .we(wrapWe),
        .log_count(wrapCount), .full(wrapFull), .wrapped(wrapWrapped),
        .drop_cnt(wrapDrop), .busy(wrapBusy)
    );

    function automatic logic [52:0] mkRec(input logic [15:0] ts, input logic [2:0] code,
                                          input logic [15:0] pcV, input logic [15:0] addr,
                                          input logic en, input logic wr);
        return {ts, code, pcV, addr, en, wr};
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [5:0] evt);
        src_evt = evt;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        totalChecks++;
        assert (obs === exp) else begin
            badChecks++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1; src_evt = '0; pc = '0; data_addr = '0; dma_addr = '0;
        data_en = 1'b0; data_wr = 1'b0; dma_en = 1'b0; clr_ram = 1'b0; freeze = 1'b0;
        repeat (3) stepCycle();
        checkOutput("rst_we", 64'(mainWe), 64'd0);
        checkOutput("rst_data", 64'(mainWrData), 64'd0);
        checkOutput("rst_addr", 64'(mainWrAddr), 64'd0);
        checkOutput("rst_count", 64'(mainCount), 64'd0);
        checkOutput("rst_full", 64'(mainFull), 64'd0);
        checkOutput("rst_wrapped", 64'(mainWrapped), 64'd0);
        checkOutput("rst_drop", 64'(mainDrop), 64'd0);
        checkOutput("rst_busy", 64'(mainBusy), 64'd0);
        reset = 1'b0;

        // Single event, snapshot taken with ts = 0
        pc = 16'h1234; data_addr = 16'hABCD; data_en = 1'b1; data_wr = 1'b1;
        applyStimulus(6'b000010);
        stepCycle();
        checkOutput("single_we", 64'(mainWe), 64'd1);
        checkOutput("single_addr", 64'(mainWrAddr), 64'd0);
        checkOutput("single_busy", 64'(mainBusy), 64'd1);
        checkOutput("single_rec", 64'(mainWrData), 64'(mkRec(16'd0, 3'd1, 16'h1234, 16'hABCD, 1'b1, 1'b1)));
        pc = 16'hFFFF; data_addr = 16'h0000;
        stepCycle();
        checkOutput("single_idle_we", 64'(mainWe), 64'd0);
        checkOutput("single_idle_data", 64'(mainWrData), 64'd0);
        checkOutput("single_idle_busy", 64'(mainBusy), 64'd0);
        checkOutput("single_next_addr", 64'(mainWrAddr), 64'd1);
        checkOutput("single_count", 64'(mainCount), 64'd1);
        stepCycle();
        checkOutput("held_no_relog", 64'(mainWe), 64'd0);

        // Batch of sources 0, 3, 5 captured at ts = 3; source 4 rises mid-drain
        pc = 16'h5555; data_addr = 16'h1111; data_en = 1'b0; data_wr = 1'b1;
        dma_addr = 16'h2222; dma_en = 1'b1;
        applyStimulus(6'b101011);
        stepCycle();
        checkOutput("batch0_we", 64'(mainWe), 64'd1);
        checkOutput("batch0_addr", 64'(mainWrAddr), 64'd1);
        checkOutput("batch0_rec", 64'(mainWrData), 64'(mkRec(16'd3, 3'd0, 16'h5555, 16'h1111, 1'b0, 1'b1)));
        pc = 16'h9999; dma_addr = 16'h7777;
        applyStimulus(6'b111011);
        stepCycle();
        checkOutput("batch1_addr", 64'(mainWrAddr), 64'd2);
        checkOutput("batch1_rec", 64'(mainWrData), 64'(mkRec(16'd3, 3'd3, 16'h5555, 16'h2222, 1'b1, 1'b0)));
        checkOutput("busy_drop", 64'(mainDrop), 64'd1);
        stepCycle();
        checkOutput("batch2_addr", 64'(mainWrAddr), 64'd3);
        checkOutput("batch2_busy", 64'(mainBusy), 64'd1);
        checkOutput("batch2_rec", 64'(mainWrData), 64'(mkRec(16'd3, 3'd5, 16'h5555, 16'h2222, 1'b1, 1'b0)));
        stepCycle();
        checkOutput("batch_end_busy", 64'(mainBusy), 64'd0);
        checkOutput("batch_end_we", 64'(mainWe), 64'd0);
        checkOutput("batch_end_addr", 64'(mainWrAddr), 64'd4);
        checkOutput("batch_end_count", 64'(mainCount), 64'd4);
        checkOutput("batch_end_drop", 64'(mainDrop), 64'd1);

        // Freeze drops a new edge; held level does not log after unfreezing
        applyStimulus(6'b000000);
        stepCycle();
        freeze = 1'b1;
        applyStimulus(6'b000100);
        stepCycle();
        checkOutput("freeze_we", 64'(mainWe), 64'd0);
        checkOutput("freeze_drop", 64'(mainDrop), 64'd2);
        freeze = 1'b0;
        stepCycle();
        checkOutput("unfreeze_held", 64'(mainBusy), 64'd0);

        // Freeze raised mid-drain must not abort the batch
        applyStimulus(6'b000111);
        stepCycle();
        checkOutput("fdrain0_we", 64'(mainWe), 64'd1);
        checkOutput("fdrain0_code", 64'(mainWrData[36:34]), 64'd0);
        freeze = 1'b1;
        stepCycle();
        checkOutput("fdrain1_we", 64'(mainWe), 64'd1);
        checkOutput("fdrain1_code", 64'(mainWrData[36:34]), 64'd1);
        checkOutput("fdrain1_addr", 64'(mainWrAddr), 64'd5);
        freeze = 1'b0;
        applyStimulus(6'b000000);
        stepCycle();
        checkOutput("fdrain_count", 64'(mainCount), 64'd6);

        // Synchronous clear; the edge in the clear cycle is discarded
        clr_ram = 1'b1;
        applyStimulus(6'b001000);
        stepCycle();
        clr_ram = 1'b0;
        checkOutput("clr_addr", 64'(mainWrAddr), 64'd0);
        checkOutput("clr_count", 64'(mainCount), 64'd0);
        checkOutput("clr_drop", 64'(mainDrop), 64'd0);
        checkOutput("clr_busy", 64'(mainBusy), 64'd0);
        checkOutput("clr_we", 64'(mainWe), 64'd0);
        stepCycle();
        checkOutput("clr_edge_gone", 64'(mainWe), 64'd0);
        checkOutput("clr_edge_nodrop", 64'(mainDrop), 64'd0);

        // Five single events into 4-entry logs: stop mode vs wrap mode
        for (int k = 0; k < 5; k++) begin
            applyStimulus(6'b000001);
            stepCycle();
            checkOutput($sformatf("stop_we%0d", k), 64'(stopWe), (k < 4) ? 64'd1 : 64'd0);
            checkOutput($sformatf("stop_addr%0d", k), 64'(stopWrAddr), 64'(k % 4));
            checkOutput($sformatf("wrap_we%0d", k), 64'(wrapWe), 64'd1);
            checkOutput($sformatf("wrap_addr%0d", k), 64'(wrapWrAddr), 64'(k % 4));
            checkOutput($sformatf("wrap_flag%0d", k), 64'(wrapWrapped), 64'd0);
            applyStimulus(6'b000000);
            stepCycle();
        end
        checkOutput("stop_full", 64'(stopFull), 64'd1);
        checkOutput("stop_count", 64'(stopCount), 64'd4);
        checkOutput("stop_drop", 64'(stopDrop), 64'd1);
        checkOutput("wrap_full", 64'(wrapFull), 64'd1);
        checkOutput("wrap_count", 64'(wrapCount), 64'd4);
        checkOutput("wrap_wrapped", 64'(wrapWrapped), 64'd1);
        checkOutput("wrap_next_addr", 64'(wrapWrAddr), 64'd1);

        // Async reset mid-drain; source 4 held across release logs once, no stale record
        pc = 16'hBEEF; dma_addr = 16'hCAFE; dma_en = 1'b1;
        applyStimulus(6'b000110);
        stepCycle();
        checkOutput("pre_rst_we", 64'(mainWe), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_we", 64'(mainWe), 64'd0);
        checkOutput("async_data", 64'(mainWrData), 64'd0);
        checkOutput("async_busy", 64'(mainBusy), 64'd0);
        applyStimulus(6'b010000);
        stepCycle();
        stepCycle();
        reset = 1'b0;
        checkOutput("release_no_stale", 64'(mainWe), 64'd0);
        stepCycle();
        checkOutput("release_we", 64'(mainWe), 64'd1);
        checkOutput("release_addr", 64'(mainWrAddr), 64'd0);
        checkOutput("release_rec", 64'(mainWrData), 64'(mkRec(16'd0, 3'd4, 16'hBEEF, 16'hCAFE, 1'b1, 1'b0)));
        stepCycle();
        checkOutput("release_done_we", 64'(mainWe), 64'd0);
        checkOutput("release_done_busy", 64'(mainBusy), 64'd0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
